boron_scheduler: RTL and testbench

Round-robin scheduler that shares one round-iterative Boron encryption core (64-bit block, 80-bit key) between two requesters. It accepts a key/plaintext job from either requester over a valid/ready handshake and launches the core with a one-cycle start pulse. It waits for the core's done pulse, with a watchdog, and returns the ciphertext tagged with the requester ID over a valid/ready response channel. It sits between the system's crypto clients and the Boron wrapper.

---
 rtl/boron_scheduler.sv | 145 ++++++++++++++
 tb/tb_boron_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boron_scheduler.sv
// boron_scheduler: round-robin arbiter that shares one iterative Boron core
// between two requesters. It accepts one job at a time, launches the core,
// watches for completion with a watchdog, and returns the ciphertext tagged
// with the owning requester.
module boron_scheduler #(
  parameter int Key_Bit_Size   = 80,
  parameter int Timeout_Cycles = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [Key_Bit_Size-1:0] req0_key,
  input  logic [63:0]             req0_pt,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [Key_Bit_Size-1:0] req1_key,
  input  logic [63:0]             req1_pt,
  output logic                    core_start,
  output logic [Key_Bit_Size-1:0] core_key,
  output logic [63:0]             core_pt,
  input  logic                    core_done,
  input  logic [63:0]             core_ct,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [63:0]             rsp_ct,
  output logic                    rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Watchdog counts 0 .. Timeout_Cycles-1 while waiting on the core.
  localparam int CNT_W = (Timeout_Cycles > 2) ? $clog2(Timeout_Cycles) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Timeout_Cycles - 1);
  localparam logic [Key_Bit_Size-1:0] KEY_ZERO = {Key_Bit_Size{1'b0}};

  state_t           state_r;
  logic             last_grant_r;   // also identifies the job in flight
  logic [CNT_W-1:0] wdog_cnt_r;

  logic             grant_id_s;
  logic             any_valid_s;

  // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    grant_id_s  = 1'b0;
    any_valid_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id_s  = ~last_grant_r;
      any_valid_s = 1'b1;
    end else if (req0_valid) begin
      grant_id_s  = 1'b0;
      any_valid_s = 1'b1;
    end else if (req1_valid) begin
      grant_id_s  = 1'b1;
      any_valid_s = 1'b1;
    end else begin
      grant_id_s  = 1'b0;
      any_valid_s = 1'b0;
    end
  end

  // Ready is offered only in IDLE and only to the winning, valid requester.
  assign req0_ready = (state_r == ST_IDLE) && req0_valid && !grant_id_s;
  assign req1_ready = (state_r == ST_IDLE) && req1_valid &&  grant_id_s;

  // Scheduler FSM: capture job, pulse start, wait with watchdog, hold response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      wdog_cnt_r   <= CNT_ZERO;
      core_start   <= 1'b0;
      core_key     <= KEY_ZERO;
      core_pt      <= 64'h0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_ct       <= 64'h0;
      rsp_err      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_valid_s) begin
            // Requester inputs are sampled only here; later changes are ignored.
            last_grant_r <= grant_id_s;
            core_key     <= grant_id_s ? req1_key : req0_key;
            core_pt      <= grant_id_s ? req1_pt  : req0_pt;
            core_start   <= 1'b1;
            state_r      <= ST_LAUNCH;
          end else begin
            core_start   <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          core_start <= 1'b0;
          wdog_cnt_r <= CNT_ZERO;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          wdog_cnt_r <= wdog_cnt_r + CNT_ONE;
          if (core_done) begin
            // Completion takes priority over a coincident watchdog expiry.
            rsp_ct    <= core_ct;
            rsp_err   <= 1'b0;
            rsp_id    <= last_grant_r;
            rsp_valid <= 1'b1;
            state_r   <= ST_RESP;
          end else if (wdog_cnt_r == CNT_LAST) begin
            rsp_ct    <= 64'h0;
            rsp_err   <= 1'b1;
            rsp_id    <= last_grant_r;
            rsp_valid <= 1'b1;
            state_r   <= ST_RESP;
          end else begin
            state_r   <= ST_WAIT;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            rsp_valid <= 1'b1;
            state_r   <= ST_RESP;
          end
        end
        default: begin
          core_start <= 1'b0;
          rsp_valid  <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boron_scheduler.sv
// Directed bench for boron_scheduler with a cycle-accurate core model and a
// response scoreboard.
module tb_boron_scheduler;

  localparam int KEY_W      = 80;
  localparam int NUM_ROUNDS = 26;
  localparam int TIMEOUT    = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req0_valid = 1'b0;
  logic              req0_ready;
  logic [KEY_W-1:0]  req0_key = '0;
  logic [63:0]       req0_pt = '0;
  logic              req1_valid = 1'b0;
  logic              req1_ready;
  logic [KEY_W-1:0]  req1_key = '0;
  logic [63:0]       req1_pt = '0;
  logic              core_start;
  logic [KEY_W-1:0]  core_key;
  logic [63:0]       core_pt;
  logic              core_done;
  logic [63:0]       core_ct;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_id;
  logic [63:0]       rsp_ct;
  logic              rsp_err;

  typedef struct {
    logic        id;
    logic [63:0] ct;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Core model controls
  int          core_delay = NUM_ROUNDS;
  logic        core_en = 1'b1;
  logic        inj_done = 1'b0;
  logic        model_busy = 1'b0;
  logic        model_done = 1'b0;
  int          model_cnt = 0;
  logic [63:0] model_ct = 64'h0;

  boron_scheduler #(.Key_Bit_Size(KEY_W), .Timeout_Cycles(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_pt(req0_pt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_pt(req1_pt),
    .core_start(core_start), .core_key(core_key), .core_pt(core_pt),
    .core_done(core_done), .core_ct(core_ct),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_ct(rsp_ct),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Cycle index of the current clock period
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: done pulses core_delay cycles after the start pulse
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (model_busy) begin
      if (model_cnt == core_delay - 1) begin
        model_done <= core_en;
        model_busy <= 1'b0;
      end
      model_cnt <= model_cnt + 1;
    end else if (core_start) begin
      model_busy <= 1'b1;
      model_cnt  <= 1;
      model_ct   <= core_pt ^ core_key[63:0];
    end
  end

  assign core_done = model_done | inj_done;
  assign core_ct   = model_ct;

  // Global time guard
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_rsp(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 80'(sb.size() > 0), 80'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rsp_id"},  80'(rsp_id),  80'(e.id));
      check({tag, "_rsp_ct"},  80'(rsp_ct),  80'(e.ct));
      check({tag, "_rsp_err"}, 80'(rsp_err), 80'(e.err));
    end
  endtask

  task automatic wait_rsp(input string tag, input int t0, input int exp_lat);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_rsp_valid"}, 80'(rsp_valid), 80'(1));
    if (rsp_valid === 1'b1) begin
      check({tag, "_latency"}, 80'(cyc - t0), 80'(exp_lat));
      compare_rsp(tag);
    end
  endtask

  task automatic send(input logic id, input logic [79:0] key, input logic [63:0] pt,
                      input logic exp_err, output int t);
    int   n;
    logic rdy;
    exp_t e;
    if (id) begin
      req1_key = key; req1_pt = pt; req1_valid = 1'b1;
    end else begin
      req0_key = key; req0_pt = pt; req0_valid = 1'b1;
    end
    #1;
    n = 0;
    rdy = id ? req1_ready : req0_ready;
    while (rdy !== 1'b1 && n < 100) begin
      tick();
      n++;
      rdy = id ? req1_ready : req0_ready;
    end
    check("accept_ready", 80'(rdy), 80'(1));
    t = cyc;
    e.id  = id;
    e.ct  = exp_err ? 64'h0 : (pt ^ key[63:0]);
    e.err = exp_err;
    sb.push_back(e);
    tick();
    // Scramble requester inputs after the handshake; the job must not change.
    if (id) begin
      req1_valid = 1'b0; req1_key = ~key; req1_pt = ~pt;
    end else begin
      req0_valid = 1'b0; req0_key = ~key; req0_pt = ~pt;
    end
    check("launch_start", 80'(core_start), 80'(1));
    check("launch_key",   core_key,        key);
    check("launch_pt",    80'(core_pt),    80'(pt));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_core_start"}, 80'(core_start), 80'(0));
    check({tag, "_core_key"},   core_key,        80'(0));
    check({tag, "_core_pt"},    80'(core_pt),    80'(0));
    check({tag, "_rsp_valid"},  80'(rsp_valid),  80'(0));
    check({tag, "_rsp_id"},     80'(rsp_id),     80'(0));
    check({tag, "_rsp_ct"},     80'(rsp_ct),     80'(0));
    check({tag, "_rsp_err"},    80'(rsp_err),    80'(0));
    check({tag, "_req0_ready"}, 80'(req0_ready), 80'(0));
    check({tag, "_req1_ready"}, 80'(req1_ready), 80'(0));
  endtask

  initial begin
    int          t;
    int          cnt;
    int          gcnt;
    int          rcnt;
    int          n;
    int          grants[4];
    int          t_acc[4];
    logic        hs;
    logic        gid;
    logic        h_id;
    logic [63:0] h_ct;
    logic        h_err;
    exp_t        e;

    // Reset: all outputs zero
    reset = 1'b1;
    repeat (5) tick();
    check_all_zero("reset");
    reset = 1'b0;
    rsp_ready = 1'b1;

    // Test 1: single job from requester 0
    send(1'b0, 80'h0, 64'h0123456789ABCDEF, 1'b0, t);
    tick();
    check("t1_start_fall", 80'(core_start), 80'(0));
    wait_rsp("t1", t, NUM_ROUNDS + 2);
    tick();
    check("t1_rsp_drop", 80'(rsp_valid), 80'(0));

    // Test 2: fairness with both requesters permanently valid
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    req0_key = {16'($urandom), $urandom, $urandom}; req0_pt = {$urandom, $urandom};
    req1_key = {16'($urandom), $urandom, $urandom}; req1_pt = {$urandom, $urandom};
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    gcnt = 0; rcnt = 0; n = 0; gid = 1'b0;
    while (rcnt < 4 && n < 400) begin
      #1;
      hs = 1'b0;
      if (gcnt < 4 && (req0_ready || req1_ready)) begin
        gid = req1_ready;
        grants[gcnt] = int'(gid);
        t_acc[gcnt]  = cyc;
        gcnt++;
        e.id  = gid;
        e.ct  = gid ? (req1_pt ^ req1_key[63:0]) : (req0_pt ^ req0_key[63:0]);
        e.err = 1'b0;
        sb.push_back(e);
        hs = 1'b1;
      end
      if (rsp_valid) begin
        compare_rsp("t2");
        rcnt++;
      end
      tick();
      n++;
      if (hs) begin
        if (gid) begin
          req1_key = {16'($urandom), $urandom, $urandom}; req1_pt = {$urandom, $urandom};
        end else begin
          req0_key = {16'($urandom), $urandom, $urandom}; req0_pt = {$urandom, $urandom};
        end
        if (gcnt == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
    end
    check("t2_rsp_count", 80'(rcnt), 80'(4));
    check("t2_grant_count", 80'(gcnt), 80'(4));
    for (int i = 0; i < 4; i++) begin
      check("t2_grant_order", 80'(grants[i]), 80'(i % 2));
    end
    for (int i = 1; i < 4; i++) begin
      check("t2_accept_spacing", 80'(t_acc[i] - t_acc[i-1]), 80'(NUM_ROUNDS + 3));
    end
    tick();

    // Test 3: watchdog timeout, then a late done that must be ignored
    core_en = 1'b0;
    send(1'b0, 80'h1234_5678_9ABC_DEF0_1357, 64'hFEDC_BA98_7654_3210, 1'b1, t);
    wait_rsp("t3", t, TIMEOUT + 2);
    tick();
    check("t3_rsp_drop", 80'(rsp_valid), 80'(0));
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    cnt = 0;
    repeat (80) begin
      if (rsp_valid || core_start) cnt++;
      tick();
    end
    check("t3_no_second_rsp", 80'(cnt), 80'(0));
    core_en = 1'b1;

    // Test 4: response backpressure
    rsp_ready = 1'b0;
    send(1'b1, 80'hAAAA_5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_1234_8765, 1'b0, t);
    wait_rsp("t4", t, NUM_ROUNDS + 2);
    h_id = rsp_id; h_ct = rsp_ct; h_err = rsp_err;
    req0_key = 80'h0000_1111_2222_3333_4444; req0_pt = 64'h5555_6666_7777_8888;
    req1_key = 80'h9999_AAAA_BBBB_CCCC_DDDD; req1_pt = 64'hEEEE_FFFF_0000_1111;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_valid", 80'(rsp_valid),  80'(1));
      check("t4_hold_id",    80'(rsp_id),     80'(h_id));
      check("t4_hold_ct",    80'(rsp_ct),     80'(h_ct));
      check("t4_hold_err",   80'(rsp_err),    80'(h_err));
      check("t4_req0_ready", 80'(req0_ready), 80'(0));
      check("t4_req1_ready", 80'(req1_ready), 80'(0));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("t4_rsp_drop", 80'(rsp_valid), 80'(0));
    // Tie after a requester-1 grant goes to requester 0
    check("t4_next_req0_ready", 80'(req0_ready), 80'(1));
    check("t4_next_req1_ready", 80'(req1_ready), 80'(0));
    t = cyc;
    e.id = 1'b0; e.ct = req0_pt ^ req0_key[63:0]; e.err = 1'b0;
    sb.push_back(e);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t4_next_start", 80'(core_start), 80'(1));
    wait_rsp("t4b", t, NUM_ROUNDS + 2);
    tick();

    // Test 5: done coincides with the last watchdog count
    core_delay = TIMEOUT;
    send(1'b1, 80'h0BAD_CAFE_DEAD_BEEF_0001, 64'hC001_D00D_FACE_B00C, 1'b0, t);
    wait_rsp("t5", t, TIMEOUT + 2);
    tick();
    core_delay = NUM_ROUNDS;

    // Test 6: reset in the middle of WAIT drops the job
    send(1'b0, 80'h1111_2222_3333_4444_5555, 64'h6666_7777_8888_9999, 1'b0, t);
    n = 0;
    while (cyc < t + 10 && n < 20) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("t6_after_reset");
    sb.delete();
    cnt = 0;
    repeat (30) begin
      if (rsp_valid || core_start) cnt++;
      tick();
    end
    check("t6_no_rsp", 80'(cnt), 80'(0));
    send(1'b1, 80'hFFFF_0000_FFFF_0000_FFFF, 64'h0123_4567_0123_4567, 1'b0, t);
    wait_rsp("t6", t, NUM_ROUNDS + 2);
    tick();
    check("sb_drained", 80'(sb.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
